// File: rtl/wishbone_pkg.sv
// Shared types and constants for the pipelined Wishbone RAM target.
package wishbone_pkg;

  localparam int unsigned LatencyMin = 1;
  localparam int unsigned LatencyMax = 4;

  typedef enum logic [1:0] {
    RespNone = 2'd0,
    RespAck  = 2'd1,
    RespErr  = 2'd2
  } resp_kind_t;

  // Termination kind for the request presented this cycle.
  function automatic resp_kind_t resp_kind(input logic accept, input logic in_range);
    if (!accept) return RespNone;
    return in_range ? RespAck : RespErr;
  endfunction

endpackage

// File: rtl/wishbone_byte_ram.sv
// Synchronous single-port RAM with per-lane write enables and a registered read.
module wishbone_byte_ram #(
  parameter  int unsigned Depth       = 1024,
  parameter  int unsigned DataWidth   = 32,
  parameter  int unsigned Granularity = 8,
  localparam int unsigned SelWidth    = DataWidth / Granularity,
  localparam int unsigned AddrW       = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic                 re_i,
  input  logic [AddrW-1:0]     addr_i,
  input  logic [SelWidth-1:0]  sel_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] rdata_q;

  // Contents are deliberately not reset so data survives a bus reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < SelWidth; i++) begin
        if (sel_i[i]) mem_q[addr_i][i*Granularity +: Granularity] <= wdata_i[i*Granularity +: Granularity];
      end
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wishbone_ram_target.sv
// Pipelined Wishbone B4 target: accept/range check, fixed-latency response pipe, abort on CYC drop.
module wishbone_ram_target import wishbone_pkg::*; #(
  parameter  int unsigned AddressWidth = 16,
  parameter  int unsigned DataWidth    = 32,
  parameter  int unsigned Granularity  = 8,
  parameter  int unsigned TGDWidth     = 1,
  parameter  int unsigned Depth        = 1024,
  parameter  int unsigned Latency      = 1,
  localparam int unsigned SELWidth     = DataWidth / Granularity
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CYC,
  input  logic                    STB,
  input  logic                    WE,
  input  logic [AddressWidth-1:0] ADDR,
  input  logic [SELWidth-1:0]     SEL,
  input  logic [DataWidth-1:0]    DAT_ToTarget,
  input  logic [TGDWidth-1:0]     TGD_ToTarget,
  input  logic                    ForceStall,
  output logic                    STALL,
  output logic                    ACK,
  output logic                    ERR,
  output logic                    RTY,
  output logic [DataWidth-1:0]    DAT_ToInitiator,
  output logic [TGDWidth-1:0]     TGD_ToInitiator
);

  localparam int unsigned RamAw = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [AddressWidth:0] DepthLim = (AddressWidth+1)'(Depth);

  typedef struct packed {
    resp_kind_t          kind;
    logic                rd;
    logic [TGDWidth-1:0] tag;
  } stage_t;

  localparam stage_t StageIdle = '{kind: RespNone, rd: 1'b0, tag: '0};

  logic                 accept, in_range;
  logic [DataWidth-1:0] ram_rdata;
  stage_t               stage_d;
  stage_t               stage_q [Latency];
  stage_t               last;
  logic [DataWidth-1:0] dat_w [Latency];

  assign STALL    = RST | ForceStall;
  assign accept   = CYC & STB & ~STALL;
  assign in_range = {1'b0, ADDR} < DepthLim;

  always_comb begin
    stage_d = '{kind: resp_kind(accept, in_range), rd: accept & ~WE & in_range, tag: TGD_ToTarget};
  end

  wishbone_byte_ram #(
    .Depth      (Depth),
    .DataWidth  (DataWidth),
    .Granularity(Granularity)
  ) u_ram (
    .clk_i  (CLK),
    .we_i   (accept & WE & in_range),
    .re_i   (stage_d.rd),
    .addr_i (ADDR[RamAw-1:0]),
    .sel_i  (SEL),
    .wdata_i(DAT_ToTarget),
    .rdata_o(ram_rdata)
  );

  // Stage 0 is loaded at the accept edge; CYC low flushes everything in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < Latency; k++) stage_q[k] <= StageIdle;
    end else if (!CYC) begin
      for (int k = 0; k < Latency; k++) stage_q[k] <= StageIdle;
    end else begin
      stage_q[0] <= stage_d;
      for (int k = 1; k < Latency; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  // Read data leaves the RAM register alongside stage 0 and shifts in lockstep.
  assign dat_w[0] = ram_rdata;
  for (genvar k = 1; k < Latency; k++) begin : g_dat
    logic [DataWidth-1:0] dat_q;
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) dat_q <= '0;
      else     dat_q <= dat_w[k-1];
    end
    assign dat_w[k] = dat_q;
  end

  assign last            = stage_q[Latency-1];
  assign ACK             = (last.kind == RespAck);
  assign ERR             = (last.kind == RespErr);
  assign RTY             = 1'b0;
  assign DAT_ToInitiator = (ACK && last.rd) ? dat_w[Latency-1] : '0;
  assign TGD_ToInitiator = (ACK || ERR) ? last.tag : '0;

endmodule

// File: tb/tb_wishbone_ram_target.sv
// Directed bench: three targets (Latency 1/3/4) share one initiator bus.
module tb_wishbone_ram_target;

  localparam int NI = 3;
  localparam int Lats [NI] = '{1, 3, 4};

  logic        CLK = 1'b0;
  logic        RST, CYC, STB, WE, FS;
  logic [15:0] ADDR;
  logic [3:0]  SEL;
  logic [31:0] DAT;
  logic [0:0]  TGD;

  logic [NI-1:0]       stall, ack, err, rty;
  logic [NI-1:0][31:0] dato;
  logic [NI-1:0][0:0]  tgdo;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    wishbone_ram_target #(
      .AddressWidth(16), .DataWidth(32), .Granularity(8),
      .TGDWidth(1), .Depth(1024), .Latency(Lats[g])
    ) u_dut (
      .CLK(CLK), .RST(RST), .CYC(CYC), .STB(STB), .WE(WE),
      .ADDR(ADDR), .SEL(SEL), .DAT_ToTarget(DAT), .TGD_ToTarget(TGD),
      .ForceStall(FS), .STALL(stall[g]), .ACK(ack[g]), .ERR(err[g]), .RTY(rty[g]),
      .DAT_ToInitiator(dato[g]), .TGD_ToInitiator(tgdo[g])
    );
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, want);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic req(input logic w, input logic [15:0] a, input logic [3:0] s,
                     input logic [31:0] d, input logic t);
    CYC = 1'b1; STB = 1'b1; WE = w; ADDR = a; SEL = s; DAT = d; TGD = t;
  endtask

  task automatic idle();
    STB = 1'b0; WE = 1'b0;
  endtask

  initial begin
    logic [15:0] acc;
    logic        want;
    int          p, nack;

    RST = 1'b1; CYC = 1'b0; STB = 1'b0; WE = 1'b0; FS = 1'b0;
    ADDR = '0; SEL = '0; DAT = '0; TGD = '0;
    #2;
    chk("rst_stall", 32'(stall[0]), 1);
    chk("rst_ack",   32'(ack[0]),   0);
    chk("rst_err",   32'(err[0]),   0);
    chk("rst_rty",   32'(rty[0]),   0);
    chk("rst_dat",   dato[0],       0);
    chk("rst_tgd",   32'(tgdo[0]),  0);
    tick(); tick();
    RST = 1'b0; #1;
    chk("stall_released", 32'(stall[0]), 0);

    // Latency 1: write then read-after-write
    req(1'b1, 16'h010, 4'hF, 32'hDEADBEEF, 1'b0); tick();
    chk("wr_ack", 32'(ack[0]), 1);
    chk("wr_err", 32'(err[0]), 0);
    req(1'b0, 16'h010, 4'h0, 32'h0, 1'b1); tick();
    chk("rd_ack", 32'(ack[0]), 1);
    chk("rd_dat", dato[0], 32'hDEADBEEF);
    chk("rd_tgd", 32'(tgdo[0]), 1);
    idle(); tick();
    chk("ack_one_cycle", 32'(ack[0]), 0);

    // Byte-lane write
    req(1'b1, 16'h020, 4'hF, 32'h11223344, 1'b0); tick();
    req(1'b1, 16'h020, 4'h5, 32'hAABBCCDD, 1'b0); tick();
    req(1'b0, 16'h020, 4'hF, 32'h0, 1'b0); tick();
    chk("sel_ack", 32'(ack[0]), 1);
    chk("sel_dat", dato[0], 32'h11BB33DD);
    idle(); tick();

    for (int i = 0; i < 8; i++) begin
      req(1'b1, 16'(i), 4'hF, 32'hA0000000 | 32'(i), 1'b0); tick();
    end
    idle(); tick(); tick(); tick(); tick();

    // Latency 3 back-to-back reads
    for (int c = 0; c < 12; c++) begin
      if (c < 8) req(1'b0, 16'(c), 4'hF, 32'h0, 1'b0);
      else idle();
      #1;
      if (c < 8) chk("b2b_stall", 32'(stall[1]), 0);
      tick();
      want = (c >= 2 && c <= 9);
      chk("b2b_ack", 32'(ack[1]), 32'(want));
      if (want) chk("b2b_dat", dato[1], 32'hA0000000 | 32'(c - 2));
    end
    idle(); tick(); tick();

    // Out of range
    req(1'b0, 16'h0400, 4'hF, 32'h0, 1'b1); tick();
    chk("oor_err", 32'(err[0]), 1);
    chk("oor_ack", 32'(ack[0]), 0);
    chk("oor_dat", dato[0], 0);
    chk("oor_tgd", 32'(tgdo[0]), 1);
    req(1'b1, 16'h0400, 4'hF, 32'h55555555, 1'b0); tick();
    chk("oor_wr_err", 32'(err[0]), 1);
    req(1'b0, 16'h0000, 4'hF, 32'h0, 1'b0); tick();
    chk("oor_noalias_ack", 32'(ack[0]), 1);
    chk("oor_noalias_dat", dato[0], 32'hA0000000);
    idle(); tick(); tick(); tick();

    // ForceStall mid-burst on Latency 3
    acc = '0; p = 0; nack = 0;
    for (int c = 0; c < 14; c++) begin
      FS = (c == 2 || c == 3);
      if (p < 6) req(1'b0, 16'(p), 4'hF, 32'h0, 1'b0);
      else idle();
      #1;
      chk("fs_stall", 32'(stall[1]), 32'(FS));
      tick();
      acc[c] = (p < 6) && !FS;
      if (acc[c]) p++;
      want = (c >= 2) ? acc[c-2] : 1'b0;
      chk("fs_ack", 32'(ack[1]), 32'(want));
      if (want) begin
        chk("fs_dat", dato[1], 32'hA0000000 | 32'(nack));
        nack++;
      end
    end
    FS = 1'b0; idle(); tick(); tick(); tick();

    // Latency 4 abort
    req(1'b0, 16'h0000, 4'hF, 32'h0, 1'b0); tick();
    req(1'b0, 16'h0001, 4'hF, 32'h0, 1'b0); tick();
    req(1'b0, 16'h0002, 4'hF, 32'h0, 1'b0); tick();
    idle(); CYC = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("abort_ack", 32'(ack[2]), 0);
      chk("abort_err", 32'(err[2]), 0);
    end

    // Reset mid-burst
    req(1'b1, 16'h030, 4'hF, 32'hCAFEF00D, 1'b0); tick();
    req(1'b0, 16'h030, 4'hF, 32'h0, 1'b0); tick();
    chk("pre_rst_ack", 32'(ack[0]), 1);
    RST = 1'b1; #1;
    chk("mid_rst_ack",   32'(ack[0]),   0);
    chk("mid_rst_stall", 32'(stall[0]), 1);
    idle(); tick();
    RST = 1'b0;
    tick();
    chk("post_rst_lost_ack3", 32'(ack[1]), 0);
    req(1'b0, 16'h030, 4'hF, 32'h0, 1'b0); tick();
    chk("post_rst_ack", 32'(ack[0]), 1);
    chk("post_rst_dat", dato[0], 32'hCAFEF00D);
    req(1'b0, 16'h010, 4'hF, 32'h0, 1'b0); tick();
    chk("post_rst_old_dat", dato[0], 32'hDEADBEEF);
    idle(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wishbone_ram_target.md
# wishbone_ram_target

Pipelined Wishbone B4 target wrapping a synchronous byte-lane RAM. It sits on the target side of the bus and answers CYC/STB requests from any initiator with one ACK or ERR per accepted request, in order, after a fixed latency. It supports back-to-back pipelined accesses, SEL byte-lane writes, external stall, and abort on CYC drop. It is the standard memory endpoint for bench initiators and for small on-chip scratch memories.

## Interface
- AddressWidth, 16: width of ADDR; word address in DataWidth units.
- DataWidth, 32: data bus width; one of 8/16/32/64.
- Granularity, 8: byte-lane width; SELWidth = DataWidth/Granularity.
- TGDWidth, 1: data tag width; the tag is echoed back with the response.
- Depth, 1024: RAM words; must satisfy Depth <= 2^AddressWidth.
- Latency, 1: accept-to-response cycles, 1..4.

Ports:
- CLK  in  1  bus clock.
- RST  in  1  reset; one clock; reset is asynchronous and active-high.
- CYC  in  1  cycle valid.
- STB  in  1  strobe.
- WE  in  1  1 = write.
- ADDR  in  AddressWidth  word address.
- SEL  in  SELWidth  byte-lane enables.
- DAT_ToTarget  in  DataWidth  write data.
- TGD_ToTarget  in  TGDWidth  request tag.
- ForceStall  in  1  external back-pressure.
- STALL  out  1  request not accepted this cycle.
- ACK  out  1  normal termination.
- ERR  out  1  error termination.
- RTY  out  1  retry; permanently 0.
- DAT_ToInitiator  out  DataWidth  read data; valid while ACK is high.
- TGD_ToInitiator  out  TGDWidth  echoed tag; valid while ACK or ERR is high.

## Operation
- STALL = RST | ForceStall, combinational.
- A request is accepted on a rising edge where CYC & STB & !STALL.
- The address is in range iff ADDR < Depth.
- Write, in range: lanes with SEL[i]=1 are written at the accept edge; other lanes are unchanged. SEL=0 is a legal no-op and is still ACKed.
- Read, in range: the full word is read. SEL does not affect read data.
- Out of range: no RAM write. The response is ERR with DAT_ToInitiator=0.
- Each accepted request enters a Latency-deep response pipeline. Each stage holds {kind: None/Ack/Err, data, tag}, and the final stage drives ACK/ERR/DAT/TGD.
- ACK and ERR are never high together.
- Abort: on any edge where CYC is sampled low, all pipeline stages are cleared to None. Writes already committed remain committed.
- RAM order equals acceptance order: a read accepted the cycle after a write to the same address returns the new data.

## Timing
- Reset values (async):
  - STALL=1 while RST is high.
  - ACK=ERR=RTY=0.
  - DAT_ToInitiator=0, TGD_ToInitiator=0.
  - All pipeline stages None.
  - RAM contents are not reset.
- A request accepted at edge N gives ACK/ERR high for exactly one cycle, starting at edge N+Latency.
- Throughput is one request per cycle. Back-to-back accepts give contiguous ACKs.
- ForceStall high: no accept. In-flight responses continue to drain.
- CYC falling while a response is in flight: no ACK/ERR from edge of the drop onward. A response already driven in the drop cycle may be ignored by the initiator.
- RST asserted mid-burst: outputs clear immediately, pending responses are lost, and writes committed before RST are retained.
- At the first edge after RST deasserts, STALL follows ForceStall only.

## Structure
- Shared package wishbone_pkg:
  - enum resp_kind_t {RespNone, RespAck, RespErr}.
  - Latency bounds constants.
- Sub-module wishbone_byte_ram: synchronous RAM with a per-lane write enable and a registered read; parameters Depth, DataWidth, Granularity.
- Top level: accept logic, range check, response pipeline, abort clear.

## Test plan
- Write 0xDEADBEEF to 0x010 with SEL=0xF, then read 0x010 (Latency=1) -> ACK one cycle after each accept; read data 0xDEADBEEF; tag echoed.
- Pre-fill 0x020 with 0x11223344, write 0xAABBCCDD with SEL=0x5, then read -> 0x11BB33DD.
- 8 back-to-back reads of 0x000..0x007 (Latency=3, CYC/STB held high) -> 8 contiguous ACKs starting 3 cycles after the first accept, data in order, STALL=0 throughout.
- Read 0x0400 (= Depth) with TGD=1 -> ERR=1, ACK=0, DAT=0, TGD=1; write to 0x0400 leaves 0x000 unchanged.
- ForceStall high for 2 cycles mid-burst -> no accepts in those cycles, in-flight ACKs still emitted, no response lost or duplicated.
- Latency=4: issue 3 reads, drop CYC 2 cycles later -> no ACK after the drop. Assert RST mid-burst -> ACK=0 and STALL=1 immediately; earlier writes read back correctly after reset.
